// File: rtl/wb_unified_ram.sv
// Wishbone classic unified instruction/data RAM with programmable wait states.
// Define WB_RAM_ERR_EN to add wb_err_o and error termination for misaligned or out-of-range addresses.
module wb_unified_ram #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o
`ifdef WB_RAM_ERR_EN
    ,
    output logic        wb_err_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_dat;
    logic          lat_we;
    logic          lat_bad;

    logic          req;
    logic [AW-1:0] req_idx;
    logic          req_bad;

    logic          go_ack;
    logic [AW-1:0] op_idx;
    logic [31:0]   op_dat;
    logic          op_we;
    logic          op_bad;

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_idx = wb_adr_i[AW+1:2];

`ifdef WB_RAM_ERR_EN
    localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    assign req_bad = (wb_adr_i[1:0] != 2'b00) || ({1'b0, wb_adr_i} >= DEPTH_BYTES);
`else
    assign req_bad = 1'b0;
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};
`endif

    // With zero wait states the access completes on the request edge itself,
    // so the operands come straight from the bus instead of the latches.
    always_comb begin
        go_ack = 1'b0;
        op_idx = lat_idx;
        op_dat = lat_dat;
        op_we  = lat_we;
        op_bad = lat_bad;
        if (state == S_IDLE && req && WS == 4'd0) begin
            go_ack = 1'b1;
            op_idx = req_idx;
            op_dat = wb_dat_i;
            op_we  = wb_we_i;
            op_bad = req_bad;
        end else if (state == S_WAIT && req && wait_cnt == 4'd1) begin
            go_ack = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && go_ack && op_we && !op_bad) begin
            mem[op_idx] <= op_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
`ifdef WB_RAM_ERR_EN
            wb_err_o <= 1'b0;
`endif
        end else begin
            wb_ack_o <= 1'b0;
`ifdef WB_RAM_ERR_EN
            wb_err_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_idx  <= req_idx;
                        lat_dat  <= wb_dat_i;
                        lat_we   <= wb_we_i;
                        lat_bad  <= req_bad;
                        wait_cnt <= WS;
                        state    <= (WS == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (go_ack) begin
`ifdef WB_RAM_ERR_EN
                if (op_bad) begin
                    wb_err_o <= 1'b1;
                end else begin
                    wb_ack_o <= 1'b1;
                    if (!op_we) wb_dat_o <= mem[op_idx];
                end
`else
                wb_ack_o <= 1'b1;
                if (!op_we) wb_dat_o <= mem[op_idx];
`endif
            end
        end
    end

endmodule
